// File: rtl/button_event_if.sv
// button_event_if: debounced button level in, event pulses and hold status out.
// The master drives btn_level and the slave (button_event) drives the event outputs.
interface button_event_if;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic       repeat_pulse;
  logic       held;
  logic [7:0] repeat_count;

  modport master (
    output btn_level,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse,
    input  repeat_pulse,
    input  held,
    input  repeat_count
  );

  modport slave (
    input  btn_level,
    output press_pulse,
    output release_pulse,
    output long_pulse,
    output repeat_pulse,
    output held,
    output repeat_count
  );
endinterface

// File: rtl/button_event.sv
// button_event: debounced level -> press/release/long/repeat one-cycle pulses.
// Optional auto-repeat while held is built when BUTTON_EVENT_REPEAT_EN is defined.
module button_event #(
  parameter int CNT_W         = 26,
  parameter int LONG_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input logic          clk,
  input logic          rst,
  button_event_if.slave bus
);

  if (LONG_CYCLES < 2 || REPEAT_CYCLES < 2 ||
      longint'(LONG_CYCLES) >= (64'd1 << CNT_W) ||
      longint'(REPEAT_CYCLES) >= (64'd1 << CNT_W)) begin : g_cfg_err
    $error("button_event: LONG/REPEAT_CYCLES out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS,
    S_HOLD
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_press;
  logic             r_release;
  logic             r_long;
  logic             r_held;
  logic             w_press;
  logic             w_release;
  logic             w_long;
  logic             w_held_nxt;
  logic             w_long_hit;

  assign w_long_hit = (r_cnt == LONG_LAST);

`ifdef BUTTON_EVENT_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic       r_repeat;
  logic       w_repeat;
  logic [7:0] r_rc;
  logic [7:0] w_rc_nxt;
  logic       w_rep_hit;

  assign w_rep_hit = (r_cnt == REP_LAST);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      r_held    <= 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
      r_repeat  <= 1'b0;
      r_rc      <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_press   <= w_press;
      r_release <= w_release;
      r_long    <= w_long;
      r_held    <= w_held_nxt;
`ifdef BUTTON_EVENT_REPEAT_EN
      r_repeat  <= w_repeat;
      r_rc      <= w_rc_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.btn_level) w_state_nxt = S_PRESS;
      end
      S_PRESS: begin
        if (!bus.btn_level) w_state_nxt = S_IDLE;
        else if (w_long_hit) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (!bus.btn_level) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next registered outputs; release is tested first so it beats thresholds.
  always_comb begin
    w_press    = 1'b0;
    w_release  = 1'b0;
    w_long     = 1'b0;
    w_held_nxt = r_held;
    w_cnt_nxt  = r_cnt;
`ifdef BUTTON_EVENT_REPEAT_EN
    w_repeat   = 1'b0;
    w_rc_nxt   = r_rc;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (bus.btn_level) begin
          w_press   = 1'b1;
          w_cnt_nxt = '0;
`ifdef BUTTON_EVENT_REPEAT_EN
          w_rc_nxt  = '0;
`endif
        end
      end
      S_PRESS: begin
        if (!bus.btn_level) begin
          w_release = 1'b1;
          w_cnt_nxt = '0;
        end else if (w_long_hit) begin
          w_long     = 1'b1;
          w_held_nxt = 1'b1;
          w_cnt_nxt  = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_HOLD: begin
        if (!bus.btn_level) begin
          w_release  = 1'b1;
          w_held_nxt = 1'b0;
          w_cnt_nxt  = '0;
        end else begin
`ifdef BUTTON_EVENT_REPEAT_EN
          if (w_rep_hit) begin
            w_repeat  = 1'b1;
            w_cnt_nxt = '0;
            w_rc_nxt  = (r_rc == 8'hFF) ? r_rc : r_rc + 8'd1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
`else
          w_cnt_nxt = '0;
`endif
        end
      end
      default: begin
        w_held_nxt = 1'b0;
        w_cnt_nxt  = '0;
      end
    endcase
  end

  assign bus.press_pulse   = r_press;
  assign bus.release_pulse = r_release;
  assign bus.long_pulse    = r_long;
  assign bus.held          = r_held;

`ifdef BUTTON_EVENT_REPEAT_EN
  assign bus.repeat_pulse  = r_repeat;
  assign bus.repeat_count  = r_rc;
`else
  assign bus.repeat_pulse  = 1'b0;
  assign bus.repeat_count  = 8'd0;
`endif

endmodule

// File: tb/tb_button_event.sv
// tb_button_event: directed + random stimulus against an event-time reference model.
// Repeat expectations follow BUTTON_EVENT_REPEAT_EN, so both builds use this bench.
module tb_button_event;

  localparam int L = 8;
  localparam int R = 4;
`ifdef BUTTON_EVENT_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  button_event_if bus ();

  button_event #(
    .CNT_W        (26),
    .LONG_CYCLES  (L),
    .REPEAT_CYCLES(R)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: a hold is described by how many held edges followed the press.
  bit m_pressed = 1'b0;
  int m_t       = 0;
  int m_rc      = 0;
  bit e_press, e_release, e_long, e_repeat, e_held;

  task automatic model(input logic b, input logic r);
    e_press   = 1'b0;
    e_release = 1'b0;
    e_long    = 1'b0;
    e_repeat  = 1'b0;
    if (r) begin
      m_pressed = 1'b0;
      m_t       = 0;
      m_rc      = 0;
    end else if (!m_pressed) begin
      if (b) begin
        e_press   = 1'b1;
        m_pressed = 1'b1;
        m_t       = 0;
        m_rc      = 0;
      end
    end else if (!b) begin
      e_release = 1'b1;
      m_pressed = 1'b0;
      m_t       = 0;
    end else begin
      m_t = m_t + 1;
      if (m_t == L) begin
        e_long = 1'b1;
      end else if (REP_EN && m_t > L && ((m_t - L) % R) == 0) begin
        e_repeat = 1'b1;
        if (m_rc < 255) m_rc = m_rc + 1;
      end
    end
    e_held = m_pressed && (m_t >= L);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic b, input logic r);
    logic [12:0] obs;
    logic [12:0] exp;
    bus.btn_level = b;
    rst = r;
    @(posedge clk);
    model(b, r);
    #1;
    obs = {bus.press_pulse, bus.release_pulse, bus.long_pulse,
           bus.repeat_pulse, bus.held, bus.repeat_count};
    exp = {e_press, e_release, e_long, e_repeat, e_held, 8'(m_rc)};
    chk("outputs", 32'(obs), 32'(exp));
    chk("onehot", 32'($countones(obs[12:9]) <= 1), 32'd1);
  endtask

  task automatic hold_n(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0);
  endtask

  initial begin
    bus.btn_level = 1'b1;

    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("reset_press", 32'(bus.press_pulse), 32'd0);

    step(1'b1, 1'b0);
    chk("first_press", 32'(bus.press_pulse), 32'd1);
    hold_n(2);
    step(1'b0, 1'b0);
    chk("tap_release", 32'(bus.release_pulse), 32'd1);
    step(1'b0, 1'b0);

    step(1'b1, 1'b0);
    hold_n(20);
    chk("hold20_count", 32'(bus.repeat_count), REP_EN ? 32'd3 : 32'd0);
    chk("hold20_held", 32'(bus.held), 32'd1);
    step(1'b0, 1'b0);
    chk("hold20_release", 32'(bus.release_pulse), 32'd1);
    chk("hold20_unheld", 32'(bus.held), 32'd0);

    step(1'b1, 1'b0);
    chk("repress", 32'(bus.press_pulse), 32'd1);
    step(1'b0, 1'b0);

    step(1'b1, 1'b0);
    hold_n(7);
    step(1'b0, 1'b0);
    chk("edge_release", 32'(bus.release_pulse), 32'd1);
    chk("edge_nolong", 32'(bus.long_pulse), 32'd0);
    step(1'b0, 1'b0);
    chk("edge_held", 32'(bus.held), 32'd0);

    step(1'b1, 1'b0);
    hold_n(300 * R + L);
    chk("sat_count", 32'(bus.repeat_count), REP_EN ? 32'd255 : 32'd0);
    step(1'b0, 1'b0);

    step(1'b1, 1'b0);
    hold_n(12);
    step(1'b1, 1'b1);
    chk("rst_norelease", 32'(bus.release_pulse), 32'd0);
    step(1'b1, 1'b0);
    chk("rst_repress", 32'(bus.press_pulse), 32'd1);
    step(1'b0, 1'b0);

    for (int k = 0; k < 250; k++) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 3 * L);
      for (int j = 0; j < len; j++) step(lvl, ($urandom_range(0, 99) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
